byte_word_bridge: RTL and testbench

- Core-side master that moves whole 32-bit words over the controller's 8-bit byte-lane register interface (byte_sel / byte data / write enable).
- A word write is serialized into four byte-lane writes. A word read is four byte-lane reads reassembled into one word.
- It is the initiator for the byte-enabled register bank. It lets 32-bit logic (DMA, command sequencer) program and poll registers without per-byte sequencing.
- A per-byte ack watchdog reports an error if a byte transfer stalls.

---
 rtl/byte_word_bridge.sv | 176 +++++++++++++++++
 tb/tb_byte_word_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_bridge.sv
// Core-side master that carries 32-bit word reads/writes over an 8-bit byte-lane
// register interface, with a per-byte ack watchdog that aborts stalled transfers.
module byte_word_bridge #(
  parameter int ADDR_WIDTH = 4,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic                  b_stb,
  output logic                  b_we,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [1:0]            b_sel,
  output logic [7:0]            b_dat_o,
  input  logic [7:0]            b_dat_i,
  input  logic                  b_ack
);

  // Counter only needs to reach TIMEOUT-1 before the abort fires.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]    FIRST_LANE = MSB_FIRST ? 2'd3 : 2'd0;
  localparam logic [1:0]    LAST_LANE  = MSB_FIRST ? 2'd0 : 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    b_stb_q, b_stb_d;
  logic                    b_we_q, b_we_d;
  logic [ADDR_WIDTH-1:0]   b_addr_q, b_addr_d;
  logic [1:0]              b_sel_q, b_sel_d;
  logic [7:0]              b_dat_o_q, b_dat_o_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [1:0]              sel_nxt;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] s);
    logic [31:0] sh;
    sh = w >> {s, 3'b000};
    return sh[7:0];
  endfunction

  assign sel_nxt = MSB_FIRST ? (b_sel_q - 2'd1) : (b_sel_q + 2'd1);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    b_stb_d   = b_stb_q;
    b_we_d    = b_we_q;
    b_addr_d  = b_addr_q;
    b_sel_d   = b_sel_q;
    b_dat_o_d = b_dat_o_q;
    wdata_d   = wdata_q;
    tmo_d     = tmo_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d   = XFER;
          busy_d    = 1'b1;
          b_stb_d   = 1'b1;
          b_we_d    = we;
          b_addr_d  = addr;
          wdata_d   = wdata;
          b_sel_d   = FIRST_LANE;
          b_dat_o_d = lane_byte(wdata, FIRST_LANE);
          tmo_d     = '0;
          if (!we) begin
            rdata_d = '0;
          end
        end
      end

      XFER: begin
        if (b_ack) begin
          if (!b_we_q) begin
            for (int l = 0; l < 4; l++) begin
              if (b_sel_q == 2'(l)) begin
                rdata_d[8*l +: 8] = b_dat_i;
              end
            end
          end
          tmo_d = '0;
          if (b_sel_q == LAST_LANE) begin
            state_d = DONE;
            b_stb_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            b_sel_d   = sel_nxt;
            b_dat_o_d = lane_byte(wdata_q, sel_nxt);
          end
        end else if ((TIMEOUT > 0) && (tmo_q == TMO_LAST)) begin
          // Ack checked first above, so a late ack on the expiry cycle still wins.
          state_d = DONE;
          b_stb_d = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else if (TIMEOUT > 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        b_stb_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      b_stb_q   <= 1'b0;
      b_we_q    <= 1'b0;
      b_addr_q  <= '0;
      b_sel_q   <= '0;
      b_dat_o_q <= '0;
      wdata_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      b_stb_q   <= b_stb_d;
      b_we_q    <= b_we_d;
      b_addr_q  <= b_addr_d;
      b_sel_q   <= b_sel_d;
      b_dat_o_q <= b_dat_o_d;
      wdata_q   <= wdata_d;
      tmo_q     <= tmo_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign b_stb   = b_stb_q;
  assign b_we    = b_we_q;
  assign b_addr  = b_addr_q;
  assign b_sel   = b_sel_q;
  assign b_dat_o = b_dat_o_q;

endmodule

// File: tb/tb_byte_word_bridge.sv
// Bench for byte_word_bridge: two instances (LSB-first with TIMEOUT=4, MSB-first with
// watchdog disabled) checked every cycle against a transaction-level model.
module tb_byte_word_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;

  logic        busy[2], done[2], err[2], b_stb[2], b_we[2];
  logic [31:0] rdata[2];
  logic [3:0]  b_addr[2];
  logic [1:0]  b_sel[2];
  logic [7:0]  b_dat_o[2];
  logic [7:0]  b_dat_i[2] = '{8'h00, 8'h00};
  logic        b_ack[2] = '{1'b0, 1'b0};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  byte_word_bridge #(.ADDR_WIDTH(4), .MSB_FIRST(1'b0), .TIMEOUT(4)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .rdata(rdata[0]),
    .b_stb(b_stb[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_sel(b_sel[0]),
    .b_dat_o(b_dat_o[0]), .b_dat_i(b_dat_i[0]), .b_ack(b_ack[0]));

  byte_word_bridge #(.ADDR_WIDTH(4), .MSB_FIRST(1'b1), .TIMEOUT(0)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .rdata(rdata[1]),
    .b_stb(b_stb[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_sel(b_sel[1]),
    .b_dat_o(b_dat_o[1]), .b_dat_i(b_dat_i[1]), .b_ack(b_ack[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Register-bank responder: fixed wait per lane or random acks, optional withhold.
  int rmode[2]    = '{0, 0};
  int wait_n[2]   = '{0, 0};
  bit withhold[2] = '{1'b0, 1'b0};
  int dmode[2]    = '{0, 0};
  int rcnt[2]     = '{0, 0};
  int racks[2]    = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit a;
      if (rst || !b_stb[i]) begin
        rcnt[i]    = 0;
        racks[i]   = 0;
        b_ack[i]   = (rmode[i] != 0) ? 1'($urandom % 2) : 1'b0;
        b_dat_i[i] = 8'($urandom);
      end else begin
        a = (rmode[i] != 0) ? 1'($urandom % 2) : (rcnt[i] >= wait_n[i]);
        if (withhold[i] && racks[i] >= 1) a = 1'b0;
        b_ack[i] = a;
        case (dmode[i])
          1:       b_dat_i[i] = 8'((32'(b_sel[i]) + 1) * 17);
          2:       b_dat_i[i] = 8'hEE;
          default: b_dat_i[i] = 8'($urandom);
        endcase
        if (a) begin
          rcnt[i] = 0;
          racks[i]++;
        end else begin
          rcnt[i]++;
        end
      end
    end
  end

  // Transaction-level model: phase 0 idle, 1 moving lanes, 2 completion cycle.
  int          p_msb[2] = '{0, 1};
  int          p_tmo[2] = '{4, 0};
  int          mph[2], mk[2], msel[2], mwt[2];
  bit          mwe[2], mab[2];
  logic [3:0]  maddr[2];
  logic [31:0] mwd[2], mrd[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mph[i] = 0; mk[i] = 0; msel[i] = 0; mwt[i] = 0;
        mwe[i] = 1'b0; mab[i] = 1'b0; maddr[i] = '0; mwd[i] = '0; mrd[i] = '0;
      end else begin
        case (mph[i])
          0: if (req) begin
            mwe[i] = we; maddr[i] = addr; mwd[i] = wdata;
            mk[i] = 0; msel[i] = p_msb[i] ? 3 : 0; mwt[i] = 0; mph[i] = 1;
            if (!we) mrd[i] = '0;
          end
          1: if (b_ack[i]) begin
            if (!mwe[i]) mrd[i][8*msel[i] +: 8] = b_dat_i[i];
            mwt[i] = 0;
            if (mk[i] == 3) begin
              mph[i] = 2; mab[i] = 1'b0;
            end else begin
              mk[i]++;
              msel[i] = p_msb[i] ? 3 - mk[i] : mk[i];
            end
          end else begin
            mwt[i]++;
            if (p_tmo[i] > 0 && mwt[i] >= p_tmo[i]) begin
              mph[i] = 2; mab[i] = 1'b1;
            end
          end
          default: mph[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] sh;
        sh = mwd[i] >> (8 * msel[i]);
        chk($sformatf("u%0d_busy", i),  32'(busy[i]),    32'(mph[i] != 0));
        chk($sformatf("u%0d_done", i),  32'(done[i]),    32'(mph[i] == 2));
        chk($sformatf("u%0d_err", i),   32'(err[i]),     32'(mph[i] == 2 && mab[i]));
        chk($sformatf("u%0d_stb", i),   32'(b_stb[i]),   32'(mph[i] == 1));
        chk($sformatf("u%0d_sel", i),   32'(b_sel[i]),   32'(msel[i]));
        chk($sformatf("u%0d_dato", i),  32'(b_dat_o[i]), 32'(sh[7:0]));
        chk($sformatf("u%0d_bwe", i),   32'(b_we[i]),    32'(mwe[i]));
        chk($sformatf("u%0d_baddr", i), 32'(b_addr[i]),  32'(maddr[i]));
        chk($sformatf("u%0d_rdata", i), rdata[i],        mrd[i]);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    req = 1'b0;
    while ((busy[0] || busy[1]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_bound", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic issue(input bit w, input logic [3:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
  endtask

  initial begin
    logic [7:0] zb[4];
    logic [7:0] mb[4];
    int cnt, dn, d1, d2, n;

    zb = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    mb = '{8'h01, 8'h02, 8'h03, 8'h04};

    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 32'(busy[i]), 0);   chk("rst_done", 32'(done[i]), 0);
      chk("rst_err", 32'(err[i]), 0);     chk("rst_stb", 32'(b_stb[i]), 0);
      chk("rst_sel", 32'(b_sel[i]), 0);   chk("rst_rdata", rdata[i], 0);
      chk("rst_dato", 32'(b_dat_o[i]), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write, LSB-first lane order.
    issue(1'b1, 4'd5, 32'hA1B2C3D4);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      req = 1'b0;
      chk("zw_stb", 32'(b_stb[0]), 1);
      chk("zw_sel", 32'(b_sel[0]), 32'(j));
      chk("zw_dat", 32'(b_dat_o[0]), 32'(zb[j]));
      chk("zw_addr", 32'(b_addr[0]), 32'd5);
    end
    @(negedge clk);
    chk("zw_done_c6", 32'(done[0]), 1);
    chk("zw_err", 32'(err[0]), 0);
    chk("zw_stb_off", 32'(b_stb[0]), 0);
    wait_idle();

    // MSB-first write.
    issue(1'b1, 4'd3, 32'h01020304);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      req = 1'b0;
      chk("msb_sel", 32'(b_sel[1]), 32'(3 - j));
      chk("msb_dat", 32'(b_dat_o[1]), 32'(mb[j]));
    end
    wait_idle();

    // Read with two wait cycles per lane.
    wait_n[0] = 2; dmode[0] = 1;
    issue(1'b0, 4'd9, 32'h0);
    cnt = 0; n = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      if (b_stb[0]) cnt++;
      n++;
    end while (!done[0] && n < 60);
    chk("rd_done_seen", 32'(done[0]), 1);
    chk("rd_stb_cycles", 32'(cnt), 32'd12);
    chk("rd_rdata", rdata[0], 32'h44332211);
    wait_idle();

    // Watchdog abort after lane 0.
    wait_n[0] = 0; dmode[0] = 2; withhold[0] = 1'b1;
    issue(1'b0, 4'd2, 32'h0);
    cnt = 0; n = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      if (b_stb[0]) cnt++;
      n++;
    end while (!done[0] && n < 60);
    chk("to_stb_cycles", 32'(cnt), 32'd5);
    chk("to_done", 32'(done[0]), 1);
    chk("to_err", 32'(err[0]), 1);
    chk("to_rdata", rdata[0], 32'h000000EE);
    withhold[0] = 1'b0; dmode[0] = 0;
    wait_idle();

    // req held high: accepted only in IDLE.
    issue(1'b1, 4'd7, 32'hCAFEF00D);
    dn = 0; d1 = 0; d2 = 0;
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk);
      if (c == 8) req = 1'b0;
      if (done[0]) begin
        dn++;
        if (dn == 1) d1 = c; else d2 = c;
      end
    end
    chk("hold_done_count", 32'(dn), 32'd2);
    chk("hold_done1_cycle", 32'(d1), 32'd6);
    chk("hold_done2_cycle", 32'(d2), 32'd12);
    wait_idle();

    // Reset during lane 2 of a write.
    issue(1'b1, 4'd4, 32'h55667788);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      req = 1'b0;
    end
    chk("mr_lane2", 32'(b_sel[0]), 32'd2);
    rst = 1'b1;
    #1;
    chk("mr_stb", 32'(b_stb[0]), 0);
    chk("mr_busy", 32'(busy[0]), 0);
    chk("mr_done", 32'(done[0]), 0);
    chk("mr_sel", 32'(b_sel[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    chk("mr_no_done", 32'(dn), 0);
    dmode[0] = 1;
    issue(1'b0, 4'd1, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      n++;
    end while (!done[0] && n < 40);
    chk("mr_fresh_done", 32'(done[0]), 1);
    chk("mr_fresh_err", 32'(err[0]), 0);
    chk("mr_fresh_rdata", rdata[0], 32'h44332211);
    wait_idle();

    // Randomized traffic with random acks and stray acks outside transfers.
    rmode = '{1, 1}; dmode = '{0, 0};
    for (int c = 0; c < 800; c++) begin
      req   = ($urandom % 3) != 0;
      we    = 1'($urandom);
      addr  = 4'($urandom);
      wdata = $urandom;
      @(negedge clk);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
